// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter.
//   REG_W / REG_ZERO : register address width and the hardwired-zero register
//   DATA_W           : register data width
//   grant_e          : which source owns the write port this cycle
//   wr_entry_t       : buffered LLU result {destination, data}
package rf_arb_pkg;

   localparam int              REG_W    = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam int              DATA_W   = 32;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WB,
      GNT_FIFO,
      GNT_LL
   } grant_e;

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO holding LLU results waiting for the register-file write port.
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push        : enqueue push_entry (ignored when full unless popping too)
//   push_entry  : {destination, data} to enqueue
//   pop         : dequeue the head (ignored when empty)
//   head        : current head entry, valid when count != 0
//   count       : occupancy, 0..DEPTH
module rf_wr_fifo
   import rf_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  wr_entry_t                push_entry,
   input  logic                     pop,
   output wr_entry_t                head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wr_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_do_push;
   logic w_do_pop;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_do_pop  = pop && !w_empty;
   assign w_do_push = push && (!w_full || w_do_pop);

   // Storage carries no reset; occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_entry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between pipeline writeback (WB) and the
// long-latency unit (LLU) result bus, with an LLU result FIFO and a
// per-register pending scoreboard for decode hazard detection.
//   clk, reset                  : clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data       : writeback request; wb_stall denies it this cycle
//   ll_issue/ll_issue_reg       : LLU op issued from decode, marks its destination pending
//   ll_valid/ll_reg/ll_data     : LLU result; accepted when ll_valid && ll_ready
//   rw/write_add/data_in        : register-file write port
//   rs_D/rt_D, busy_rs/busy_rt  : decode source lookup into the scoreboard
//   pend_count                  : FIFO occupancy
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int AGE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wb_we,
   input  logic [REG_W-1:0]       wb_addr,
   input  logic [DATA_W-1:0]      wb_data,
   output logic                   wb_stall,
   input  logic                   ll_issue,
   input  logic [REG_W-1:0]       ll_issue_reg,
   input  logic                   ll_valid,
   input  logic [REG_W-1:0]       ll_reg,
   input  logic [DATA_W-1:0]      ll_data,
   output logic                   ll_ready,
   output logic                   rw,
   output logic [REG_W-1:0]       write_add,
   output logic [DATA_W-1:0]      data_in,
   input  logic [REG_W-1:0]       rs_D,
   input  logic [REG_W-1:0]       rt_D,
   output logic                   busy_rs,
   output logic                   busy_rt,
   output logic [$clog2(DEPTH):0] pend_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);

   wr_entry_t        w_fifo_head;
   wr_entry_t        w_ll_entry;
   logic [CNT_W-1:0] w_fifo_count;
   logic             w_fifo_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_ll_accept;
   logic             w_wb_req;
   logic             w_force;
   grant_e           w_grant;
   logic [31:0]      w_pend_set;
   logic [31:0]      w_pend_clr;

   // Head age kept as cycles-remaining: AGE_MAX means a fresh head, 0 means
   // the head has waited AGE_MAX cycles and may preempt writeback.
   logic [AGE_W-1:0] r_age_left;
   logic             r_forced_last;
   logic [31:0]      r_pend;

   assign w_ll_entry   = {ll_reg, ll_data};
   assign w_fifo_empty = (w_fifo_count == '0);
   assign w_wb_req     = wb_we && (wb_addr != REG_ZERO);
   assign w_force      = !w_fifo_empty && (r_age_left == '0) && !r_forced_last;

   // ll_ready depends on registered occupancy only.
   assign ll_ready    = (w_fifo_count < CNT_W'(DEPTH));
   assign w_ll_accept = ll_valid && ll_ready;

   always_comb begin
      w_grant = GNT_NONE;
      if (w_force) begin
         w_grant = GNT_FIFO;
      end else if (w_wb_req) begin
         w_grant = GNT_WB;
      end else if (!w_fifo_empty) begin
         w_grant = GNT_FIFO;
      end else if (ll_valid) begin
         w_grant = GNT_LL;
      end
   end

   // A zero destination still consumes its grant slot but never writes.
   always_comb begin
      rw         = 1'b0;
      write_add  = REG_ZERO;
      data_in    = '0;
      w_pend_clr = '0;
      case (w_grant)
         GNT_WB: begin
            rw        = 1'b1;
            write_add = wb_addr;
            data_in   = wb_data;
         end
         GNT_FIFO: begin
            rw                          = (w_fifo_head.rd != REG_ZERO);
            write_add                   = w_fifo_head.rd;
            data_in                     = w_fifo_head.data;
            w_pend_clr[w_fifo_head.rd]  = 1'b1;
         end
         GNT_LL: begin
            rw                  = (ll_reg != REG_ZERO);
            write_add           = ll_reg;
            data_in             = ll_data;
            w_pend_clr[ll_reg]  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_pend_set = '0;
      if (ll_issue) begin
         w_pend_set[ll_issue_reg] = 1'b1;
      end
   end

   assign wb_stall = w_force && wb_we;
   assign w_pop    = (w_grant == GNT_FIFO);
   assign w_push   = w_ll_accept && (w_grant != GNT_LL);

   rf_wr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (w_push),
      .push_entry (w_ll_entry),
      .pop        (w_pop),
      .head       (w_fifo_head),
      .count      (w_fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_age_left    <= AGE_W'(AGE_MAX);
         r_forced_last <= 1'b0;
         r_pend        <= '0;
      end else begin
         if (w_pop) begin
            r_age_left <= AGE_W'(AGE_MAX);
         end else if (!w_fifo_empty && (r_age_left != '0)) begin
            r_age_left <= r_age_left - 1'b1;
         end
         r_forced_last <= w_force;
         // Set after clear so a same-cycle reissue keeps the bit; bit 0 never pends.
         r_pend <= ((r_pend & ~w_pend_clr) | w_pend_set) & ~32'h1;
      end
   end

   assign busy_rs    = r_pend[rs_D];
   assign busy_rt    = r_pend[rt_D];
   assign pend_count = w_fifo_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

   localparam int DEPTH   = 2;
   localparam int AGE_MAX = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        ll_issue;
   logic [4:0]  ll_issue_reg;
   logic        ll_valid;
   logic [4:0]  ll_reg;
   logic [31:0] ll_data;
   logic        ll_ready;
   logic        rw;
   logic [4:0]  write_add;
   logic [31:0] data_in;
   logic [4:0]  rs_D;
   logic [4:0]  rt_D;
   logic        busy_rs;
   logic        busy_rt;
   logic [1:0]  pend_count;

   rf_write_arbiter #(
      .DEPTH   (DEPTH),
      .AGE_MAX (AGE_MAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wb_we        (wb_we),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .wb_stall     (wb_stall),
      .ll_issue     (ll_issue),
      .ll_issue_reg (ll_issue_reg),
      .ll_valid     (ll_valid),
      .ll_reg       (ll_reg),
      .ll_data      (ll_data),
      .ll_ready     (ll_ready),
      .rw           (rw),
      .write_add    (write_add),
      .data_in      (data_in),
      .rs_D         (rs_D),
      .rt_D         (rt_D),
      .busy_rs      (busy_rs),
      .busy_rt      (busy_rt),
      .pend_count   (pend_count)
   );

   always #5 clk = ~clk;

   // Reference model: queue of waiting results, integer head age, pending bit vector.
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } res_t;

   res_t        mq[$];
   int          m_age;
   bit          m_forced_last;
   bit [31:0]   m_pend;

   int          n_tests = 0;
   int          n_fail  = 0;

   // Expectations for the current cycle (0 none, 1 writeback, 2 queue head, 3 direct LLU)
   int          e_src;
   bit          e_force;
   logic        e_rw;
   logic [4:0]  e_addr;
   logic [31:0] e_data;
   logic        e_stall;
   logic        e_ready;
   int          e_count;
   logic        e_brs;
   logic        e_brt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_age         = 0;
      m_forced_last = 0;
      m_pend        = '0;
   endtask

   task automatic model_eval();
      e_force = (mq.size() > 0) && (m_age >= AGE_MAX) && !m_forced_last;
      if (e_force)                            e_src = 2;
      else if (wb_we && wb_addr != 5'd0)      e_src = 1;
      else if (mq.size() > 0)                 e_src = 2;
      else if (ll_valid)                      e_src = 3;
      else                                    e_src = 0;
      e_rw   = 1'b0;
      e_addr = 5'd0;
      e_data = 32'd0;
      if (e_src == 1) begin
         e_rw = 1'b1; e_addr = wb_addr; e_data = wb_data;
      end else if (e_src == 2) begin
         e_rw = (mq[0].rd != 5'd0); e_addr = mq[0].rd; e_data = mq[0].data;
      end else if (e_src == 3) begin
         e_rw = (ll_reg != 5'd0); e_addr = ll_reg; e_data = ll_data;
      end
      e_stall = e_force && wb_we;
      e_ready = (mq.size() < DEPTH);
      e_count = mq.size();
      e_brs   = m_pend[rs_D];
      e_brt   = m_pend[rt_D];
   endtask

   task automatic model_commit();
      int clr;
      if (reset) begin
         model_reset();
         return;
      end
      clr = -1;
      if (e_src == 2) begin
         clr = mq[0].rd;
         void'(mq.pop_front());
         m_age = 0;
      end else begin
         if (e_src == 3) clr = ll_reg;
         if (mq.size() > 0 && m_age < AGE_MAX) m_age++;
      end
      if (ll_valid && e_ready && e_src != 3) mq.push_back({ll_reg, ll_data});
      if (clr >= 0) m_pend[clr] = 1'b0;
      if (ll_issue) m_pend[ll_issue_reg] = 1'b1;
      m_pend[0] = 1'b0;
      m_forced_last = e_force;
   endtask

   task automatic settle(input string tag);
      @(negedge clk);
      model_eval();
      chk({tag, ".rw"}, {31'd0, rw}, {31'd0, e_rw});
      if (e_rw) begin
         chk({tag, ".write_add"}, {27'd0, write_add}, {27'd0, e_addr});
         chk({tag, ".data_in"}, data_in, e_data);
      end
      chk({tag, ".wb_stall"}, {31'd0, wb_stall}, {31'd0, e_stall});
      chk({tag, ".ll_ready"}, {31'd0, ll_ready}, {31'd0, e_ready});
      chk({tag, ".pend_count"}, {30'd0, pend_count}, 32'(e_count));
      chk({tag, ".busy_rs"}, {31'd0, busy_rs}, {31'd0, e_brs});
      chk({tag, ".busy_rt"}, {31'd0, busy_rt}, {31'd0, e_brt});
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic step(input string tag);
      settle(tag);
      tick();
   endtask

   task automatic idle_inputs();
      reset = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
      ll_issue = 0; ll_issue_reg = 0; ll_valid = 0; ll_reg = 0; ll_data = 0;
      rs_D = 0; rt_D = 0;
   endtask

   initial begin
      int  guard;
      bit  got_it;

      idle_inputs();
      reset = 1;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      reset = 0;

      // Reset state
      settle("reset");
      chk("reset.rw", {31'd0, rw}, 32'd0);
      chk("reset.ll_ready", {31'd0, ll_ready}, 32'd1);
      chk("reset.pend_count", {30'd0, pend_count}, 32'd0);
      tick();

      // Bypass when the FIFO is idle
      ll_valid = 1; ll_reg = 5'd8; ll_data = 32'hDEAD;
      settle("bypass");
      chk("bypass.rw", {31'd0, rw}, 32'd1);
      chk("bypass.addr", {27'd0, write_add}, 32'd8);
      chk("bypass.data", data_in, 32'hDEAD);
      tick();
      ll_valid = 0;
      step("bypass_after");

      // WB / LLU collision
      wb_we = 1; wb_addr = 5'd3; wb_data = 32'h11;
      ll_valid = 1; ll_reg = 5'd9; ll_data = 32'h22;
      settle("coll");
      chk("coll.addr", {27'd0, write_add}, 32'd3);
      tick();
      wb_we = 0; ll_valid = 0;
      settle("coll_drain");
      chk("coll_drain.count", {30'd0, pend_count}, 32'd1);
      chk("coll_drain.addr", {27'd0, write_add}, 32'd9);
      chk("coll_drain.data", data_in, 32'h22);
      tick();
      settle("coll_empty");
      chk("coll_empty.count", {30'd0, pend_count}, 32'd0);
      tick();

      // Preemption under continuous writeback
      wb_we = 1; wb_addr = 5'd4; wb_data = 32'h44;
      ll_valid = 1; ll_reg = 5'd10; ll_data = 32'hA0;
      step("pre0");
      ll_valid = 0;
      for (int k = 1; k <= 6; k++) begin
         settle($sformatf("pre%0d", k));
         if (k == 5) begin
            chk("pre.forced_stall", {31'd0, wb_stall}, 32'd1);
            chk("pre.forced_addr", {27'd0, write_add}, 32'd10);
         end
         if (k == 6) begin
            chk("pre.wb_after_stall", {31'd0, wb_stall}, 32'd0);
            chk("pre.wb_after_addr", {27'd0, write_add}, 32'd4);
         end
         tick();
      end

      // Full FIFO holds a third result
      ll_valid = 1; ll_reg = 5'd13; ll_data = 32'hA13;
      step("full0");
      ll_reg = 5'd14; ll_data = 32'hA14;
      step("full1");
      ll_reg = 5'd15; ll_data = 32'hA15;
      settle("full2");
      chk("full.ready", {31'd0, ll_ready}, 32'd0);
      chk("full.count", {30'd0, pend_count}, 32'd2);
      got_it = e_ready;
      tick();
      guard = 0;
      while (!got_it && guard < 20) begin
         settle("full_hold");
         got_it = e_ready;
         tick();
         guard++;
      end
      chk("full.third_accepted", {31'd0, got_it}, 32'd1);
      ll_valid = 0; wb_we = 0;
      guard = 0;
      while (mq.size() > 0 && guard < 10) begin
         step("full_drain");
         guard++;
      end
      chk("full.drained", 32'(mq.size()), 32'd0);
      settle("full_empty");
      tick();

      // Scoreboard
      rs_D = 5'd12; rt_D = 5'd5;
      ll_issue = 1; ll_issue_reg = 5'd12;
      settle("sb_issue");
      chk("sb.not_yet", {31'd0, busy_rs}, 32'd0);
      tick();
      ll_issue = 0;
      settle("sb_busy");
      chk("sb.busy_next", {31'd0, busy_rs}, 32'd1);
      tick();
      ll_valid = 1; ll_reg = 5'd12; ll_data = 32'h1200;
      settle("sb_grant");
      chk("sb.busy_at_grant", {31'd0, busy_rs}, 32'd1);
      tick();
      ll_valid = 0;
      settle("sb_clear");
      chk("sb.cleared", {31'd0, busy_rs}, 32'd0);
      tick();
      ll_issue = 1; ll_issue_reg = 5'd12;
      step("sb_reissue");
      ll_valid = 1; ll_reg = 5'd12; ll_data = 32'h1201;
      step("sb_same_cycle");
      ll_issue = 0; ll_valid = 0;
      settle("sb_set_wins");
      chk("sb.set_wins", {31'd0, busy_rs}, 32'd1);
      tick();
      ll_valid = 1; ll_reg = 5'd12;
      step("sb_final_clear");
      ll_valid = 0;
      step("sb_idle");

      // Register 0 results
      ll_valid = 1; ll_reg = 5'd0; ll_data = 32'h55;
      settle("r0_bypass");
      chk("r0.bypass_rw", {31'd0, rw}, 32'd0);
      tick();
      wb_we = 1; wb_addr = 5'd6; wb_data = 32'h66;
      step("r0_enq");
      wb_we = 0; ll_valid = 0;
      settle("r0_deq");
      chk("r0.deq_rw", {31'd0, rw}, 32'd0);
      chk("r0.deq_count", {30'd0, pend_count}, 32'd1);
      tick();
      step("r0_idle");

      // Reset with two entries queued and a pending bit
      wb_we = 1; wb_addr = 5'd7; wb_data = 32'h77;
      ll_valid = 1; ll_reg = 5'd17; ll_data = 32'h170;
      ll_issue = 1; ll_issue_reg = 5'd20;
      rs_D = 5'd20; rt_D = 5'd20;
      step("rst_q0");
      ll_issue = 0; ll_reg = 5'd18; ll_data = 32'h180;
      step("rst_q1");
      ll_valid = 0;
      settle("rst_q2");
      chk("rst.count_before", {30'd0, pend_count}, 32'd2);
      reset = 1;
      tick();
      idle_inputs();
      rs_D = 5'd20; rt_D = 5'd20;
      settle("rst_after");
      chk("rst.count", {30'd0, pend_count}, 32'd0);
      chk("rst.busy_rs", {31'd0, busy_rs}, 32'd0);
      chk("rst.busy_rt", {31'd0, busy_rt}, 32'd0);
      chk("rst.ready", {31'd0, ll_ready}, 32'd1);
      tick();

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 499) == 0);
         if (!e_stall) begin
            wb_we   = ($urandom_range(0, 99) < 60);
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom();
            if (m_pend[wb_addr]) wb_we = 0;
         end
         if (!ll_valid || e_ready) begin
            ll_valid = ($urandom_range(0, 99) < 40);
            ll_reg   = 5'($urandom_range(0, 31));
            ll_data  = $urandom();
         end
         ll_issue     = ($urandom_range(0, 99) < 20);
         ll_issue_reg = 5'($urandom_range(0, 31));
         rs_D         = 5'($urandom_range(0, 31));
         rt_D         = 5'($urandom_range(0, 31));
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
